draw_ball_shooter: RTL and testbench

Overlay stage placed directly downstream of the shooter-POV background renderer. It consumes the background VGA stream, draws the ball as a filled circle at its current position, and forwards the stream with one cycle of latency. It also owns the ball-flight state machine: on a shot request, it moves the ball once per frame from the penalty spot towards a latched goal target, then reports landing to the game controller.

---
 rtl/draw_ball_shooter_if.sv | 13 +
 rtl/draw_ball_shooter.sv | 135 +++++++++++++
 tb/tb_draw_ball_shooter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_ball_shooter_if.sv
// VGA pixel stream shared by the render pipeline stages.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_ball_shooter.sv
// Ball overlay on the shooter-POV stream plus the per-frame ball-flight FSM.
// Output stream is the input delayed by one cycle, with ball pixels replaced.
module draw_ball_shooter #(
   parameter int unsigned SPOT_X   = 512,
   parameter int unsigned SPOT_Y   = 730,
   parameter int unsigned STEP     = 4,
   parameter int unsigned RADIUS   = 8,
   parameter logic [11:0] BALL_RGB = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   vga_if.in           in,
   vga_if.out          out,
   input  logic        shot,
   input  logic [10:0] target_x,
   input  logic [10:0] target_y,
   input  logic        ball_reset,
   output logic        landed,
   output logic        flight_done
);
   typedef enum logic [1:0] {IDLE, FLIGHT, LANDED} state_t;

   localparam logic [10:0] SPOT_X_W = 11'(SPOT_X);
   localparam logic [10:0] SPOT_Y_W = 11'(SPOT_Y);
   localparam logic [11:0] STEP_W   = 12'(STEP);
   localparam logic [23:0] RADIUS_2 = 24'(RADIUS * RADIUS);

   state_t             state, state_nxt;
   logic               vblnk_d, tick, arrive;
   logic [10:0]        pos_x, pos_y, tgt_x, tgt_y;
   logic [10:0]        pos_x_nxt, pos_y_nxt, clamp_x, clamp_y;
   logic signed [11:0] dx, dy;
   logic signed [23:0] dx_w, dy_w;
   logic [23:0]        dist2;
   logic               hit;
   logic [11:0]        rgb_nxt;

   // One step towards the target on a single axis; never overshoots.
   function automatic logic [10:0] step_axis(input logic [10:0] pos, input logic [10:0] tgt);
      logic signed [11:0] d;
      logic [11:0]        mag;
      d   = $signed({1'b0, tgt}) - $signed({1'b0, pos});
      mag = d[11] ? $unsigned(-d) : $unsigned(d);
      if (mag <= STEP_W) return tgt;
      else if (d[11])    return pos - 11'(STEP);
      else               return pos + 11'(STEP);
   endfunction

   assign tick      = in.vblnk & ~vblnk_d;
   assign pos_x_nxt = step_axis(pos_x, tgt_x);
   assign pos_y_nxt = step_axis(pos_y, tgt_y);
   assign arrive    = (pos_x_nxt == tgt_x) && (pos_y_nxt == tgt_y);
   assign clamp_x   = target_x[10] ? 11'd1023 : target_x;
   assign clamp_y   = (target_y > 11'd767) ? 11'd767 : target_y;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: defaults at the top of every always_comb keep all paths assigned, so no latches.
   always_comb begin
      state_nxt = state;
      if (ball_reset) state_nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (shot)           state_nxt = FLIGHT;
            FLIGHT:  if (tick && arrive) state_nxt = LANDED;
            default: ;
         endcase
      end
   end

   always_comb begin
      landed = (state == LANDED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_d     <= 1'b0;
         flight_done <= 1'b0;
         pos_x       <= SPOT_X_W;
         pos_y       <= SPOT_Y_W;
         tgt_x       <= SPOT_X_W;
         tgt_y       <= SPOT_Y_W;
      end else begin
         vblnk_d     <= in.vblnk;
         flight_done <= (state == FLIGHT) && (state_nxt == LANDED);
         if (ball_reset) begin
            pos_x <= SPOT_X_W;
            pos_y <= SPOT_Y_W;
         end else if (state == IDLE && shot) begin
            tgt_x <= clamp_x;
            tgt_y <= clamp_y;
         end else if (state == FLIGHT && tick) begin
            pos_x <= pos_x_nxt;
            pos_y <= pos_y_nxt;
         end
      end
   end

   // Signed offsets keep partly off-screen balls clipped instead of wrapping.
   assign dx    = $signed({1'b0, in.hcount}) - $signed({1'b0, pos_x});
   assign dy    = $signed({1'b0, in.vcount}) - $signed({1'b0, pos_y});
   assign dx_w  = {{12{dx[11]}}, dx};
   assign dy_w  = {{12{dy[11]}}, dy};
   assign dist2 = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);
   assign hit   = (dist2 <= RADIUS_2);

   always_comb begin
      rgb_nxt = in.rgb;
      if (hit && !in.hblnk && !in.vblnk) rgb_nxt = BALL_RGB;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out.hcount <= '0;
         out.vcount <= '0;
         out.hsync  <= 1'b0;
         out.vsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.rgb    <= '0;
      end else begin
         out.hcount <= in.hcount;
         out.vcount <= in.vcount;
         out.hsync  <= in.hsync;
         out.vsync  <= in.vsync;
         out.hblnk  <= in.hblnk;
         out.vblnk  <= in.vblnk;
         out.rgb    <= rgb_nxt;
      end
   end
endmodule

// File: tb/tb_draw_ball_shooter.sv
// Bench for draw_ball_shooter: a reference ball model feeds a scoreboard each cycle,
// plus table vectors and flight sequences with hand-derived landing ticks.
module tb_draw_ball_shooter;
   localparam int          SPOT_X = 512;
   localparam int          SPOT_Y = 730;
   localparam int          STEP   = 4;
   localparam int          RADIUS = 8;
   localparam logic [11:0] BALL   = 12'hFFF;
   localparam logic [11:0] BG     = 12'h0A5;

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } pix_t;

   typedef struct packed {
      pix_t pix;
      logic landed;
      logic flight_done;
   } exp_t;

   typedef struct {
      int          h;
      int          v;
      bit          hb;
      bit          vb;
      logic [11:0] exp_rgb;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        shot, ball_reset;
   logic [10:0] target_x, target_y;
   logic        landed, flight_done;

   vga_if vin ();
   vga_if vout ();

   draw_ball_shooter #(
      .SPOT_X(SPOT_X), .SPOT_Y(SPOT_Y), .STEP(STEP), .RADIUS(RADIUS), .BALL_RGB(BALL)
   ) dut (
      .clk(clk), .rst(rst), .in(vin), .out(vout), .shot(shot),
      .target_x(target_x), .target_y(target_y), .ball_reset(ball_reset),
      .landed(landed), .flight_done(flight_done)
   );

   always #5 clk = ~clk;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];

   // Reference model of the ball (0 idle, 1 flight, 2 landed).
   int m_state, mx, my, tx, ty;
   bit prev_vb;
   int tick_n, fd_count, fd_tick;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic pix_t mk(input int h, input int v, input bit hb, input bit vb,
                               input logic [11:0] rgb);
      pix_t p;
      p.hcount = 11'(h);
      p.vcount = 11'(v);
      p.hsync  = 1'($urandom);
      p.vsync  = 1'($urandom);
      p.hblnk  = hb;
      p.vblnk  = vb;
      p.rgb    = rgb;
      return p;
   endfunction

   function automatic bit model_inside(input int h, input int v);
      int ddx, ddy;
      ddx = h - mx;
      ddy = v - my;
      return (ddx * ddx + ddy * ddy) <= RADIUS * RADIUS;
   endfunction

   function automatic int model_step(input int p, input int t);
      if (t - p > STEP)  return p + STEP;
      if (p - t > STEP)  return p - STEP;
      return t;
   endfunction

   // Drive one cycle, push the expected output, then pop and compare after the edge.
   task automatic drive(input pix_t p);
      exp_t e, got;
      bit   tk;
      vin.hcount = p.hcount;
      vin.vcount = p.vcount;
      vin.hsync  = p.hsync;
      vin.vsync  = p.vsync;
      vin.hblnk  = p.hblnk;
      vin.vblnk  = p.vblnk;
      vin.rgb    = p.rgb;
      tk = p.vblnk && !prev_vb;
      e.pix = p;
      if (model_inside(int'(p.hcount), int'(p.vcount)) && !p.hblnk && !p.vblnk) e.pix.rgb = BALL;
      e.flight_done = 1'b0;
      if (rst) begin
         e = '0;
         m_state = 0; mx = SPOT_X; my = SPOT_Y; tx = SPOT_X; ty = SPOT_Y; prev_vb = 1'b0;
      end else begin
         prev_vb = p.vblnk;
         if (tk) tick_n++;
         if (ball_reset) begin
            m_state = 0; mx = SPOT_X; my = SPOT_Y;
         end else if (m_state == 0 && shot) begin
            tx = (target_x > 11'd1023) ? 1023 : int'(target_x);
            ty = (target_y > 11'd767) ? 767 : int'(target_y);
            m_state = 1;
         end else if (m_state == 1 && tk) begin
            mx = model_step(mx, tx);
            my = model_step(my, ty);
            if (mx == tx && my == ty) begin
               m_state = 2;
               e.flight_done = 1'b1;
            end
         end
         e.landed = (m_state == 2);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      got.pix = {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
      got.landed = landed;
      got.flight_done = flight_done;
      e = sb.pop_front();
      check("stream", 64'(got.pix), 64'(e.pix));
      check("landed", 64'(got.landed), 64'(e.landed));
      check("flight_done", 64'(got.flight_done), 64'(e.flight_done));
      if (flight_done === 1'b1) begin
         fd_count++;
         fd_tick = tick_n;
      end
   endtask

   // One short frame: tick cycle, another blank line, then visible pixels around the ball.
   task automatic frame(input bit abort);
      if (abort) begin
         ball_reset = 1'b1;
         shot = 1'b1;
      end
      drive(mk($urandom_range(0, 1343), 770, 1'b1, 1'b1, 12'($urandom)));
      ball_reset = 1'b0;
      shot = 1'b0;
      drive(mk($urandom_range(0, 1343), 771, 1'b1, 1'b1, 12'($urandom)));
      for (int i = 0; i < 4; i++)
         drive(mk(mx + $urandom_range(0, 24) - 12, my + $urandom_range(0, 24) - 12,
                  1'b0, 1'b0, 12'($urandom)));
   endtask

   task automatic probe(input string name, input int h, input int v, input logic [11:0] exp_rgb);
      drive(mk(h, v, 1'b0, 1'b0, BG));
      check(name, 64'(vout.rgb), 64'(exp_rgb));
   endtask

   task automatic fire(input int x, input int y);
      target_x = 11'(x);
      target_y = 11'(y);
      shot = 1'b1;
      drive(mk(0, 0, 1'b1, 1'b0, BG));
      shot = 1'b0;
      tick_n = 0; fd_count = 0; fd_tick = -1;
   endtask

   task automatic pulse_ball_reset();
      ball_reset = 1'b1;
      drive(mk(0, 0, 1'b1, 1'b0, BG));
      ball_reset = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[12];
      tbl[0]  = '{100, 100, 1'b0, 1'b0, 12'h0F0};
      tbl[1]  = '{512, 730, 1'b0, 1'b0, 12'hFFF};
      tbl[2]  = '{520, 730, 1'b0, 1'b0, 12'hFFF};
      tbl[3]  = '{512, 738, 1'b0, 1'b0, 12'hFFF};
      tbl[4]  = '{521, 730, 1'b0, 1'b0, 12'h0F0};
      tbl[5]  = '{504, 730, 1'b0, 1'b0, 12'hFFF};
      tbl[6]  = '{507, 735, 1'b0, 1'b0, 12'hFFF};
      tbl[7]  = '{506, 736, 1'b0, 1'b0, 12'h0F0};
      tbl[8]  = '{512, 730, 1'b1, 1'b0, 12'h0F0};
      tbl[9]  = '{512, 730, 1'b0, 1'b1, 12'h0F0};
      tbl[10] = '{512, 722, 1'b0, 1'b0, 12'hFFF};
      tbl[11] = '{512, 721, 1'b0, 1'b0, 12'h0F0};

      shot = 1'b0; ball_reset = 1'b0; target_x = '0; target_y = '0;
      m_state = 0; mx = SPOT_X; my = SPOT_Y; tx = SPOT_X; ty = SPOT_Y;
      prev_vb = 1'b0; tick_n = 0; fd_count = 0; fd_tick = -1;

      // Reset
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(mk(100 + i, 100, 1'b0, 1'b0, 12'h0F0));
         check("reset_rgb", 64'(vout.rgb), 64'h0);
         check("reset_landed", 64'(landed), 64'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive(mk(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, 12'h0F0));
         check($sformatf("table_%0d", i), 64'(vout.rgb), 64'(tbl[i].exp_rgb));
      end

      // Straight shot: 600 px at 4 px per tick lands at tick 150
      fire(512, 130);
      for (int t = 1; t <= 155; t++) begin
         frame(1'b0);
         if (t == 1) begin
            probe("straight_t1_above", 512, 718, BALL);
            probe("straight_t1_below", 512, 735, BG);
         end
         if (t == 149) check("straight_not_landed_149", 64'(landed), 64'h0);
      end
      check("straight_fd_count", 64'(fd_count), 64'd1);
      check("straight_fd_tick", 64'(fd_tick), 64'd150);
      check("straight_landed", 64'(landed), 64'h1);
      probe("straight_at_target", 512, 130, BALL);
      probe("straight_below_target", 512, 139, BG);

      // Diagonal: x done at tick 53, y at tick 133 with a 2 px last step
      pulse_ball_reset();
      fire(300, 200);
      for (int t = 1; t <= 140; t++) begin
         frame(1'b0);
         if (t == 52)  probe("diag_x_t52", 295, 522, BG);
         if (t == 53)  probe("diag_x_t53", 292, 518, BALL);
         if (t == 132) probe("diag_y_t132", 300, 193, BG);
         if (t == 133) probe("diag_y_t133", 300, 193, BALL);
      end
      check("diag_fd_count", 64'(fd_count), 64'd1);
      check("diag_fd_tick", 64'(fd_tick), 64'd133);

      // Second shot mid-flight is ignored; shot while landed is ignored
      pulse_ball_reset();
      fire(512, 130);
      for (int t = 1; t <= 155; t++) begin
         frame(1'b0);
         if (t == 10) begin
            target_x = 11'd900; target_y = 11'd150; shot = 1'b1;
            drive(mk(0, 0, 1'b1, 1'b0, BG));
            shot = 1'b0;
         end
      end
      check("ignored_fd_count", 64'(fd_count), 64'd1);
      check("ignored_fd_tick", 64'(fd_tick), 64'd150);
      target_x = 11'd900; target_y = 11'd150; shot = 1'b1;
      drive(mk(0, 0, 1'b1, 1'b0, BG));
      shot = 1'b0;
      frame(1'b0);
      frame(1'b0);
      check("landed_shot_landed", 64'(landed), 64'h1);
      probe("landed_shot_pos", 512, 130, BALL);
      probe("landed_shot_not_moved", 900, 150, BG);

      // Abort: ball_reset together with shot on the tick of frame 20
      pulse_ball_reset();
      fire(300, 200);
      for (int t = 1; t <= 30; t++) frame(t == 20);
      check("abort_no_fd", 64'(fd_count), 64'd0);
      check("abort_landed", 64'(landed), 64'h0);
      probe("abort_spot_bottom", 512, 738, BALL);
      probe("abort_spot_top", 512, 722, BALL);
      // Still IDLE: a shot at the spot itself completes in one tick
      fire(SPOT_X, SPOT_Y);
      for (int t = 1; t <= 3; t++) frame(1'b0);
      check("spot_fd_count", 64'(fd_count), 64'd1);
      check("spot_fd_tick", 64'(fd_tick), 64'd1);

      // Clamped target (1023,767): 511 px horizontally -> 128 ticks; ball clipped at the edge
      pulse_ball_reset();
      fire(1500, 2000);
      for (int t = 1; t <= 135; t++) frame(1'b0);
      check("clamp_fd_tick", 64'(fd_tick), 64'd128);
      probe("clamp_centre", 1023, 767, BALL);
      probe("clamp_left", 1015, 767, BALL);
      probe("clamp_outside", 1014, 767, BG);

      // Random stream in IDLE: delayed passthrough outside the circle
      pulse_ball_reset();
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0)
            drive(mk($urandom_range(0, 1100), $urandom_range(0, 800),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 12'($urandom)));
         else
            drive(mk(SPOT_X + $urandom_range(0, 20) - 10, SPOT_Y + $urandom_range(0, 20) - 10,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 12'($urandom)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
